// File: rtl/e203_itcm_pkg.sv
// +----------------------------------------------------------------------+
// | Module   : e203_itcm_pkg                                             |
// | Purpose  : Shared definitions for the ITCM front-end: requester IDs  |
// |            and the light-sleep idle threshold default.               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

package e203_itcm_pkg;

  // Requester identity, used for the response owner and the arbitration history
  typedef enum logic {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

  // Default number of idle cycles before the SRAM enters light sleep
  localparam int LS_IDLE_DEF = 8;

  // Convert the idle threshold into the width of the idle counter,
  // clamping into the legal 1..15 range
  function automatic logic [3:0] ls_thresh(input int val);
    if (val < 1) begin
      return 4'd1;
    end else if (val > 15) begin
      return 4'd15;
    end else begin
      return 4'(val);
    end
  endfunction

endpackage : e203_itcm_pkg

`default_nettype wire

// File: rtl/e203_itcm_rsp_hold.sv
// +----------------------------------------------------------------------+
// | Module   : e203_itcm_rsp_hold                                        |
// | Purpose  : Single-entry response tracker. Presents SRAM read data    |
// |            the cycle after a grant and freezes it in a hold register |
// |            while the owning port back-pressures.                     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

import e203_itcm_pkg::*;

module e203_itcm_rsp_hold #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          acc,
  input  req_id_e       acc_owner,
  input  logic          acc_wr,
  input  logic [DW-1:0] ram_dout,
  input  logic          ifu_rsp_ready,
  input  logic          lsu_rsp_ready,
  output logic          rsp_pend,
  output logic          rsp_hs,
  output logic          ifu_rsp_valid,
  output logic          lsu_rsp_valid,
  output logic [DW-1:0] rsp_rdata
);

  logic          r_pend;
  req_id_e       r_owner;
  logic          r_wr;
  logic          r_hold_vld;
  logic [DW-1:0] r_hold_data;
  logic          w_owner_ready;

  assign w_owner_ready = (r_owner == REQ_LSU) ? lsu_rsp_ready : ifu_rsp_ready;
  assign rsp_hs        = r_pend & w_owner_ready;
  assign rsp_pend      = r_pend;
  assign ifu_rsp_valid = r_pend & (r_owner == REQ_IFU);
  assign lsu_rsp_valid = r_pend & (r_owner == REQ_LSU);

  // Writes return zero; reads return live SRAM data until it has been frozen
  assign rsp_rdata = r_wr       ? '0 :
                     r_hold_vld ? r_hold_data : ram_dout;

  // Track the outstanding response and capture SRAM data on the first stall cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= 1'b0;
      r_owner     <= REQ_IFU;
      r_wr        <= 1'b0;
      r_hold_vld  <= 1'b0;
      r_hold_data <= '0;
    end else if (acc) begin
      r_pend     <= 1'b1;
      r_owner    <= acc_owner;
      r_wr       <= acc_wr;
      r_hold_vld <= 1'b0;
    end else if (rsp_hs) begin
      r_pend     <= 1'b0;
      r_hold_vld <= 1'b0;
    end else if (r_pend && !r_hold_vld) begin
      r_hold_vld  <= 1'b1;
      r_hold_data <= ram_dout;
    end
  end

endmodule : e203_itcm_rsp_hold

`default_nettype wire

// File: rtl/e203_itcm_arb.sv
// +----------------------------------------------------------------------+
// | Module   : e203_itcm_arb                                             |
// | Purpose  : IFU/LSU arbiter and sequencer for the single-port ITCM    |
// |            SRAM, with response hold and idle light-sleep control.    |
// | Config   : E203_ITCM_ARB_LSU_PRIO_EN - when defined the LSU always   |
// |            wins a conflict; otherwise round-robin arbitration.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

import e203_itcm_pkg::*;

module e203_itcm_arb #(
  parameter int BAW     = 16,
  parameter int DW      = 64,
  parameter int MW      = 8,
  parameter int AW      = BAW - 3,
  parameter int LS_IDLE = LS_IDLE_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  // IFU command / response
  input  logic           ifu_cmd_valid,
  output logic           ifu_cmd_ready,
  input  logic [BAW-1:0] ifu_cmd_addr,
  output logic           ifu_rsp_valid,
  input  logic           ifu_rsp_ready,
  output logic [DW-1:0]  ifu_rsp_rdata,
  // LSU command / response
  input  logic           lsu_cmd_valid,
  output logic           lsu_cmd_ready,
  input  logic           lsu_cmd_read,
  input  logic [BAW-1:0] lsu_cmd_addr,
  input  logic [DW-1:0]  lsu_cmd_wdata,
  input  logic [MW-1:0]  lsu_cmd_wmask,
  output logic           lsu_rsp_valid,
  input  logic           lsu_rsp_ready,
  output logic [DW-1:0]  lsu_rsp_rdata,
  // SRAM side
  output logic           ram_cs,
  output logic           ram_we,
  output logic [AW-1:0]  ram_addr,
  output logic [MW-1:0]  ram_wem,
  output logic [DW-1:0]  ram_din,
  input  logic [DW-1:0]  ram_dout,
  output logic           ram_ls,
  output logic           ram_ds,
  output logic           ram_sd
);

  localparam logic [3:0] C_LS_IDLE = ls_thresh(LS_IDLE);

  logic          w_rsp_pend;
  logic          w_rsp_hs;
  logic          w_can_acc;
  logic          w_lsu_prio;
  logic          w_ifu_acc;
  logic          w_lsu_acc;
  logic          w_acc;
  logic          w_lsu_wr;
  logic          w_any_valid;
  logic [3:0]    w_idle_nxt;
  logic [DW-1:0] w_rsp_rdata;
  logic          r_ram_ls;
  logic [3:0]    r_idle_cnt;
  logic          w_unused;

  // Command address bits below the SRAM word are not needed
  assign w_unused = ^{ifu_cmd_addr[2:0], lsu_cmd_addr[2:0]};

  // A new command may enter only when the response slot is free (or freeing) and the SRAM is awake
  assign w_can_acc = (!w_rsp_pend || w_rsp_hs) && !r_ram_ls;

`ifdef E203_ITCM_ARB_LSU_PRIO_EN
  assign w_lsu_prio = 1'b1;
`else
  req_id_e r_last_grant;

  // The LSU has priority on a conflict only if the IFU was granted last
  assign w_lsu_prio = (r_last_grant == REQ_IFU);

  // Remember the most recent grantee for round-robin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= REQ_LSU;
    end else if (w_acc) begin
      r_last_grant <= w_lsu_acc ? REQ_LSU : REQ_IFU;
    end
  end
`endif

  assign ifu_cmd_ready = w_can_acc && !(lsu_cmd_valid && w_lsu_prio);
  assign lsu_cmd_ready = w_can_acc && !(ifu_cmd_valid && !w_lsu_prio);
  assign w_ifu_acc     = ifu_cmd_valid && ifu_cmd_ready;
  assign w_lsu_acc     = lsu_cmd_valid && lsu_cmd_ready;
  assign w_acc         = w_ifu_acc || w_lsu_acc;
  assign w_lsu_wr      = w_lsu_acc && !lsu_cmd_read;

  assign ram_cs   = w_acc;
  assign ram_we   = w_lsu_wr;
  assign ram_addr = w_lsu_acc ? lsu_cmd_addr[BAW-1:3] : ifu_cmd_addr[BAW-1:3];
  assign ram_wem  = w_lsu_wr ? lsu_cmd_wmask : {MW{1'b1}};
  assign ram_din  = lsu_cmd_wdata;
  assign ram_ls   = r_ram_ls;
  assign ram_ds   = 1'b0;
  assign ram_sd   = 1'b0;

  e203_itcm_rsp_hold #(
    .DW(DW)
  ) u_rsp_hold (
    .clk           (clk),
    .rst_n         (rst_n),
    .acc           (w_acc),
    .acc_owner     (w_lsu_acc ? REQ_LSU : REQ_IFU),
    .acc_wr        (w_lsu_wr),
    .ram_dout      (ram_dout),
    .ifu_rsp_ready (ifu_rsp_ready),
    .lsu_rsp_ready (lsu_rsp_ready),
    .rsp_pend      (w_rsp_pend),
    .rsp_hs        (w_rsp_hs),
    .ifu_rsp_valid (ifu_rsp_valid),
    .lsu_rsp_valid (lsu_rsp_valid),
    .rsp_rdata     (w_rsp_rdata)
  );

  assign ifu_rsp_rdata = w_rsp_rdata;
  assign lsu_rsp_rdata = w_rsp_rdata;

  // Idle counter: quiet cycles only, saturating at the threshold
  assign w_any_valid = ifu_cmd_valid || lsu_cmd_valid;
  assign w_idle_nxt  = (w_any_valid || w_rsp_pend)  ? 4'd0 :
                       (r_idle_cnt == C_LS_IDLE)    ? r_idle_cnt :
                                                      r_idle_cnt + 4'd1;

  // Count idle cycles and drive light sleep; any request wakes the SRAM next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= 4'd0;
      r_ram_ls   <= 1'b0;
    end else begin
      r_idle_cnt <= w_idle_nxt;
      if (w_any_valid) begin
        r_ram_ls <= 1'b0;
      end else if (w_idle_nxt == C_LS_IDLE) begin
        r_ram_ls <= 1'b1;
      end
    end
  end

endmodule : e203_itcm_arb

`default_nettype wire

// File: tb/tb_e203_itcm_arb.sv
// +----------------------------------------------------------------------+
// | Module   : tb_e203_itcm_arb                                          |
// | Purpose  : Self-checking bench for e203_itcm_arb against a           |
// |            transaction-level reference model.                        |
// | Config   : honours E203_ITCM_ARB_LSU_PRIO_EN                         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_e203_itcm_arb;

  localparam int BAW     = 16;
  localparam int DW      = 64;
  localparam int MW      = 8;
  localparam int AW      = 13;
  localparam int LS_IDLE = 8;
  localparam int NWORDS  = 1 << AW;

  logic           clk;
  logic           rst_n;
  logic           ifu_cmd_valid, ifu_cmd_ready;
  logic [BAW-1:0] ifu_cmd_addr;
  logic           ifu_rsp_valid, ifu_rsp_ready;
  logic [DW-1:0]  ifu_rsp_rdata;
  logic           lsu_cmd_valid, lsu_cmd_ready, lsu_cmd_read;
  logic [BAW-1:0] lsu_cmd_addr;
  logic [DW-1:0]  lsu_cmd_wdata;
  logic [MW-1:0]  lsu_cmd_wmask;
  logic           lsu_rsp_valid, lsu_rsp_ready;
  logic [DW-1:0]  lsu_rsp_rdata;
  logic           ram_cs, ram_we, ram_ls, ram_ds, ram_sd;
  logic [AW-1:0]  ram_addr;
  logic [MW-1:0]  ram_wem;
  logic [DW-1:0]  ram_din, ram_dout;

  e203_itcm_arb #(
    .BAW(BAW), .DW(DW), .MW(MW), .AW(AW), .LS_IDLE(LS_IDLE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_cmd_valid(ifu_cmd_valid), .ifu_cmd_ready(ifu_cmd_ready), .ifu_cmd_addr(ifu_cmd_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(ifu_rsp_rdata),
    .lsu_cmd_valid(lsu_cmd_valid), .lsu_cmd_ready(lsu_cmd_ready), .lsu_cmd_read(lsu_cmd_read),
    .lsu_cmd_addr(lsu_cmd_addr), .lsu_cmd_wdata(lsu_cmd_wdata), .lsu_cmd_wmask(lsu_cmd_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_ls(ram_ls), .ram_ds(ram_ds), .ram_sd(ram_sd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM environment: responds to the DUT pins, drives garbage when not reading
  logic [DW-1:0] sram [NWORDS];
  always @(posedge clk) begin
    if (ram_cs && !ram_we) begin
      ram_dout <= sram[ram_addr];
    end else begin
      ram_dout <= {$urandom, $urandom};
    end
    if (ram_cs && ram_we) begin
      for (int b = 0; b < MW; b++) begin
        if (ram_wem[b]) sram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [NWORDS];
  bit            m_pend;
  bit            m_owner_lsu;
  logic [DW-1:0] m_data;
  bit            m_last_lsu;
  int            m_quiet;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend      = 1'b0;
    m_owner_lsu = 1'b0;
    m_data      = '0;
    m_last_lsu  = 1'b1;
    m_quiet     = 0;
  endtask

  // One clock cycle: check DUT outputs against the model, then advance the model
  task automatic step();
    bit            exp_ls, hs, free, lsu_wins, exp_ifu_acc, exp_lsu_acc, exp_wr;
    int            word;
    logic [DW-1:0] cur;
    @(negedge clk);
    exp_ls = (m_quiet >= LS_IDLE);
    hs     = m_pend && (m_owner_lsu ? lsu_rsp_ready : ifu_rsp_ready);
    free   = (!m_pend || hs) && !exp_ls;
`ifdef E203_ITCM_ARB_LSU_PRIO_EN
    lsu_wins = 1'b1;
`else
    lsu_wins = !m_last_lsu;
`endif
    exp_ifu_acc = 1'b0;
    exp_lsu_acc = 1'b0;
    if (free) begin
      if (ifu_cmd_valid && lsu_cmd_valid) begin
        if (lsu_wins) exp_lsu_acc = 1'b1;
        else          exp_ifu_acc = 1'b1;
      end else begin
        exp_ifu_acc = ifu_cmd_valid;
        exp_lsu_acc = lsu_cmd_valid;
      end
    end
    exp_wr = exp_lsu_acc && !lsu_cmd_read;

    check_val("ifu_accept", ifu_cmd_valid && ifu_cmd_ready, exp_ifu_acc);
    check_val("lsu_accept", lsu_cmd_valid && lsu_cmd_ready, exp_lsu_acc);
    check_val("ram_cs", ram_cs, exp_ifu_acc || exp_lsu_acc);
    check_val("ram_we", ram_we, exp_wr);
    check_val("ram_ls", ram_ls, exp_ls);
    check_val("ram_ds_sd", {ram_ds, ram_sd}, 2'b00);
    check_val("ifu_rsp_valid", ifu_rsp_valid, m_pend && !m_owner_lsu);
    check_val("lsu_rsp_valid", lsu_rsp_valid, m_pend && m_owner_lsu);
    if (m_pend && !m_owner_lsu) check_val("ifu_rdata", ifu_rsp_rdata, m_data);
    if (m_pend && m_owner_lsu)  check_val("lsu_rdata", lsu_rsp_rdata, m_data);
    if (exp_ifu_acc) begin
      word = int'(ifu_cmd_addr) / 8;
      check_val("ram_addr", ram_addr, 64'(word));
      check_val("ram_wem", ram_wem, 8'hFF);
    end
    if (exp_lsu_acc) begin
      word = int'(lsu_cmd_addr) / 8;
      check_val("ram_addr", ram_addr, 64'(word));
      check_val("ram_wem", ram_wem, exp_wr ? lsu_cmd_wmask : 8'hFF);
      if (exp_wr) check_val("ram_din", ram_din, lsu_cmd_wdata);
    end

    // Advance the model across the clock edge
    if (ifu_cmd_valid || lsu_cmd_valid || m_pend) m_quiet = 0;
    else m_quiet++;
    if (hs) m_pend = 1'b0;
    if (exp_ifu_acc || exp_lsu_acc) begin
      word        = exp_lsu_acc ? int'(lsu_cmd_addr) / 8 : int'(ifu_cmd_addr) / 8;
      m_pend      = 1'b1;
      m_owner_lsu = exp_lsu_acc;
      m_last_lsu  = exp_lsu_acc;
      if (exp_wr) begin
        m_data = '0;
        cur    = ref_mem[word];
        for (int b = 0; b < MW; b++) begin
          if (lsu_cmd_wmask[b]) cur[8*b +: 8] = lsu_cmd_wdata[8*b +: 8];
        end
        ref_mem[word] = cur;
      end else begin
        m_data = ref_mem[word];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_cmd_valid = 1'b0;
    lsu_cmd_valid = 1'b0;
    lsu_cmd_read  = 1'b1;
    ifu_rsp_ready = 1'b1;
    lsu_rsp_ready = 1'b1;
  endtask

  task automatic rand_inputs();
    ifu_cmd_valid = (($urandom % 100) < 55);
    lsu_cmd_valid = (($urandom % 100) < 55);
    ifu_cmd_addr  = 16'($urandom_range(0, 255));
    lsu_cmd_addr  = 16'($urandom_range(0, 255));
    lsu_cmd_read  = 1'($urandom_range(0, 1));
    lsu_cmd_wdata = {$urandom, $urandom};
    lsu_cmd_wmask = 8'($urandom);
    ifu_rsp_ready = (($urandom % 100) < 75);
    lsu_rsp_ready = (($urandom % 100) < 75);
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < NWORDS; i++) begin
      v          = {$urandom, $urandom};
      sram[i]    = v;
      ref_mem[i] = v;
    end
    rst_n         = 1'b0;
    ifu_cmd_addr  = '0;
    lsu_cmd_addr  = '0;
    lsu_cmd_wdata = '0;
    lsu_cmd_wmask = '0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
    check_val("rst_lsu_rsp_valid", lsu_rsp_valid, 1'b0);
    check_val("rst_ram_cs", ram_cs, 1'b0);
    check_val("rst_ram_ls", ram_ls, 1'b0);
    rst_n = 1'b1;

    // Simultaneous requests right after reset
    ifu_cmd_valid = 1'b1; ifu_cmd_addr = 16'h0008;
    lsu_cmd_valid = 1'b1; lsu_cmd_addr = 16'h0018; lsu_cmd_read = 1'b1;
    step();
    step();
    idle_inputs();
    step();

    // IFU read of 0x0010
    ifu_cmd_valid = 1'b1; ifu_cmd_addr = 16'h0010;
    #1 check_val("tp_ram_addr", ram_addr, 13'd2);
    step();
    idle_inputs();
    step();

    // Partial LSU write then read-back of the merged word
    lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b0; lsu_cmd_addr = 16'h0040;
    lsu_cmd_wdata = 64'hAABBCCDDEEFF0011; lsu_cmd_wmask = 8'h0F;
    step();
    lsu_cmd_read = 1'b1;
    step();
    idle_inputs();
    step();

    // Stalled IFU response while the LSU is waiting
    ifu_cmd_valid = 1'b1; ifu_cmd_addr = 16'h0020; ifu_rsp_ready = 1'b0;
    step();
    ifu_cmd_valid = 1'b0; lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b1; lsu_cmd_addr = 16'h0028;
    repeat (3) step();
    ifu_rsp_ready = 1'b1;
    step();
    idle_inputs();
    repeat (2) step();

    // Light sleep entry and wake
    repeat (LS_IDLE + 2) step();
    lsu_cmd_valid = 1'b1; lsu_cmd_addr = 16'h0030;
    repeat (2) step();
    idle_inputs();
    step();

    // Reset with a response pending
    ifu_cmd_valid = 1'b1; ifu_cmd_addr = 16'h0048; ifu_rsp_ready = 1'b0;
    step();
    ifu_cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_mid_ifu_valid", ifu_rsp_valid, 1'b0);
    check_val("rst_mid_lsu_valid", lsu_rsp_valid, 1'b0);
    model_reset();
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step();

    // Randomized traffic with periodic idle stretches
    for (int c = 0; c < 3000; c++) begin
      if ((c % 250) >= 236) idle_inputs();
      else rand_inputs();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_e203_itcm_arb

`default_nettype wire
